iob_regfile_mp: RTL and testbench

Multi-read-port register file with byte-strobed writes, per-port valid/ready read channels, optional write-to-read bypass and a hardware clear sweep. It supersedes the two-port register file for peripherals that expose one CPU write path and several concurrent read consumers, such as DMA descriptors or status mirrors. It sits between the CPU-side register interface and the core datapath.

---
 rtl/iob_regfile_mp.sv | 149 ++++++++++++++
 tb/tb_iob_regfile_mp.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_regfile_mp.sv
// Multi-read-port register file: one byte-strobed write path, NR independent
// valid/ready read channels, optional same-cycle write bypass and a clear sweep.
module iob_regfile_mp #(
  parameter int N      = 8,
  parameter int W      = 32,
  parameter int NR     = 2,
  parameter int BYPASS = 1,
  localparam int ADDR_W = $clog2(N)
) (
  input  logic                   clk_i,
  input  logic                   arst_n_i,
  input  logic                   clr_i,
  output logic                   clr_busy_o,
  output logic                   clr_done_o,
  input  logic                   wvalid_i,
  output logic                   wready_o,
  input  logic [ADDR_W-1:0]      waddr_i,
  input  logic [W/8-1:0]         wstrb_i,
  input  logic [W-1:0]           wdata_i,
  input  logic [NR-1:0]          rvalid_i,
  output logic [NR-1:0]          rready_o,
  input  logic [NR*ADDR_W-1:0]   raddr_i,
  output logic [NR-1:0]          rdvalid_o,
  input  logic [NR-1:0]          rdready_i,
  output logic [NR*W-1:0]        rdata_o
);

  localparam int NB = W / 8;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic                done_q, done_d;
  logic [W-1:0]        mem_q [N];
  logic                accept;
  logic                wfire;
  logic [NR-1:0]       rfire;
  logic [NR-1:0]       rdvalid_q;
  logic [NR*W-1:0]     rdata_q;
  logic [W-1:0]        rd_val [NR];

  function automatic logic [W-1:0] merge_bytes(input logic [W-1:0] old_val,
                                               input logic [W-1:0] new_val,
                                               input logic [NB-1:0] strb);
    logic [W-1:0] res;
    res = old_val;
    for (int b = 0; b < NB; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_i) begin
          state_d = CLEAR;
          count_d = '0;
        end
      end
      CLEAR: begin
        if (count_q == LAST) begin
          state_d = IDLE;
          count_d = '0;
          done_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // A pending clear request blocks new traffic in the same cycle it is raised.
  assign accept     = (state_q == IDLE) & ~clr_i;
  assign wready_o   = accept;
  assign wfire      = wvalid_i & accept;
  assign rready_o   = {NR{accept}} & (~rdvalid_q | rdready_i);
  assign rfire      = rvalid_i & rready_o;
  assign clr_busy_o = (state_q == CLEAR);
  assign clr_done_o = done_q;
  assign rdvalid_o  = rdvalid_q;
  assign rdata_o    = rdata_q;

  // Out-of-range addresses match no register, so reads return 0 and writes vanish.
  always_comb begin
    for (int p = 0; p < NR; p++) begin
      rd_val[p] = '0;
      for (int i = 0; i < N; i++) begin
        if (raddr_i[p*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
          if ((BYPASS != 0) && wfire && (waddr_i == ADDR_W'(i)))
            rd_val[p] = merge_bytes(mem_q[i], wdata_i, wstrb_i);
          else
            rd_val[p] = mem_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if ((state_q == CLEAR) && (count_q == ADDR_W'(i)))
          mem_q[i] <= '0;
        else if (wfire && (waddr_i == ADDR_W'(i)))
          mem_q[i] <= merge_bytes(mem_q[i], wdata_i, wstrb_i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rdvalid_q <= '0;
      rdata_q   <= '0;
    end else begin
      for (int p = 0; p < NR; p++) begin
        if (rfire[p]) begin
          rdvalid_q[p]       <= 1'b1;
          rdata_q[p*W +: W]  <= rd_val[p];
        end else if (rdready_i[p]) begin
          rdvalid_q[p] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_iob_regfile_mp.sv
// Bench for iob_regfile_mp: an N=8/BYPASS=1 and an N=6/BYPASS=0 instance share
// one stimulus stream and are each compared against a behavioural model.
module tb_iob_regfile_mp;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        clr;
  logic        wvalid;
  logic [2:0]  waddr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [1:0]  rvalid;
  logic [5:0]  raddr;
  logic [1:0]  rdready;

  logic [1:0]  o_busy, o_done, o_wready;
  logic [1:0]  o_rready  [2];
  logic [1:0]  o_rdvalid [2];
  logic [63:0] o_rdata   [2];

  int checks = 0;
  int fails  = 0;

  int          m_n   [2] = '{8, 6};
  bit          m_byp [2] = '{1'b1, 1'b0};
  logic [31:0] m_mem [2][8];
  bit          m_busy[2];
  int          m_left[2];
  bit          m_done[2];
  bit   [1:0]  m_rv  [2];
  logic [31:0] m_rd  [2][2];

  int busy_cnt[2];
  int done_cnt[2];
  logic [31:0] p1_exp [3] = '{32'hA5A5A5A5, 32'hDEADBEEF, 32'h11FF33FF};

  always #5 clk = ~clk;

  iob_regfile_mp #(.N(8), .W(32), .NR(2), .BYPASS(1)) dut_a (
    .clk_i(clk), .arst_n_i(arst_n), .clr_i(clr),
    .clr_busy_o(o_busy[0]), .clr_done_o(o_done[0]),
    .wvalid_i(wvalid), .wready_o(o_wready[0]), .waddr_i(waddr),
    .wstrb_i(wstrb), .wdata_i(wdata),
    .rvalid_i(rvalid), .rready_o(o_rready[0]), .raddr_i(raddr),
    .rdvalid_o(o_rdvalid[0]), .rdready_i(rdready), .rdata_o(o_rdata[0])
  );

  iob_regfile_mp #(.N(6), .W(32), .NR(2), .BYPASS(0)) dut_b (
    .clk_i(clk), .arst_n_i(arst_n), .clr_i(clr),
    .clr_busy_o(o_busy[1]), .clr_done_o(o_done[1]),
    .wvalid_i(wvalid), .wready_o(o_wready[1]), .waddr_i(waddr),
    .wstrb_i(wstrb), .wdata_i(wdata),
    .rvalid_i(rvalid), .rready_o(o_rready[1]), .raddr_i(raddr),
    .rdvalid_o(o_rdvalid[1]), .rdready_i(rdready), .rdata_o(o_rdata[1])
  );

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 8; a++) m_mem[k][a] = '0;
      m_busy[k] = 1'b0;
      m_left[k] = 0;
      m_done[k] = 1'b0;
      m_rv[k]   = 2'b00;
      m_rd[k][0] = '0;
      m_rd[k][1] = '0;
    end
  endtask

  task automatic checkOutput();
    bit open;
    bit rr;
    for (int k = 0; k < 2; k++) begin
      open = !m_busy[k] && !clr;
      chk($sformatf("wready[%0d]", k), 32'(o_wready[k]), 32'(open));
      for (int p = 0; p < 2; p++) begin
        rr = open && (!m_rv[k][p] || rdready[p]);
        chk($sformatf("rready[%0d][%0d]", k, p), 32'(o_rready[k][p]), 32'(rr));
        if (m_rv[k][p])
          chk($sformatf("rdata[%0d][%0d]", k, p), o_rdata[k][p*32 +: 32], m_rd[k][p]);
      end
      chk($sformatf("busy[%0d]", k), 32'(o_busy[k]), 32'(m_busy[k]));
      chk($sformatf("done[%0d]", k), 32'(o_done[k]), 32'(m_done[k]));
      chk($sformatf("rdvalid[%0d]", k), 32'(o_rdvalid[k]), 32'(m_rv[k]));
    end
  endtask

  // Advances the model by one rising edge using the inputs held across it.
  task automatic stepModel();
    bit          open, wf, rf;
    int          n, ra;
    logic [31:0] val;
    for (int k = 0; k < 2; k++) begin
      n    = m_n[k];
      open = !m_busy[k] && !clr;
      wf   = wvalid && open;
      for (int p = 0; p < 2; p++) begin
        ra = int'(raddr[p*3 +: 3]);
        rf = rvalid[p] && open && (!m_rv[k][p] || rdready[p]);
        if (rf) begin
          val = (ra < n) ? m_mem[k][ra] : 32'h0;
          if (m_byp[k] && wf && (ra == int'(waddr)) && (ra < n))
            val = merge(m_mem[k][ra], wdata, wstrb);
          m_rd[k][p] = val;
          m_rv[k][p] = 1'b1;
        end else if (rdready[p]) begin
          m_rv[k][p] = 1'b0;
        end
      end
      if (wf && (int'(waddr) < n)) m_mem[k][waddr] = merge(m_mem[k][waddr], wdata, wstrb);
      m_done[k] = 1'b0;
      if (!m_busy[k] && clr) begin
        m_busy[k] = 1'b1;
        m_left[k] = n;
      end else if (m_busy[k]) begin
        m_mem[k][n - m_left[k]] = '0;
        m_left[k]--;
        if (m_left[k] == 0) begin
          m_busy[k] = 1'b0;
          m_done[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic c, input logic wv, input logic [2:0] wa,
                               input logic [3:0] ws, input logic [31:0] wd,
                               input logic [1:0] rv, input logic [2:0] ra0,
                               input logic [2:0] ra1, input logic [1:0] rdr);
    clr = c; wvalid = wv; waddr = wa; wstrb = ws; wdata = wd;
    rvalid = rv; raddr = {ra1, ra0}; rdready = rdr;
    #1 checkOutput();
    @(posedge clk);
    stepModel();
    @(negedge clk);
  endtask

  task automatic randomCycles(input int count);
    for (int i = 0; i < count; i++)
      applyStimulus(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), 4'($urandom), $urandom,
                    2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)),
                    {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
  endtask

  initial begin
    arst_n = 1'b0; clr = 1'b0; wvalid = 1'b0; waddr = '0; wstrb = '0; wdata = '0;
    rvalid = '0; raddr = '0; rdready = '0;
    modelReset();
    #1 checkOutput();
    chk("reset_wready", 32'(o_wready), 32'h3);
    chk("reset_rready_a", 32'(o_rready[0]), 32'h3);
    chk("reset_rdata_b", o_rdata[1][31:0], 32'h0);
    @(negedge clk);
    arst_n = 1'b1;

    applyStimulus(0, 1, 3, 4'hF, 32'hA5A5A5A5, 2'b00, 0, 0, 2'b11);
    for (int a = 0; a < 8; a++) begin
      applyStimulus(0, 0, 0, 0, 0, 2'b11, 3'(a), 3'(a), 2'b11);
      for (int k = 0; k < 2; k++) begin
        chk("first_rdvalid", 32'(o_rdvalid[k]), 32'h3);
        chk("first_read_p0", o_rdata[k][31:0], (a == 3) ? 32'hA5A5A5A5 : 32'h0);
      end
    end

    applyStimulus(0, 1, 2, 4'hF, 32'h11223344, 2'b00, 0, 0, 2'b11);
    applyStimulus(0, 1, 2, 4'b0101, 32'hFFFFFFFF, 2'b00, 0, 0, 2'b11);
    applyStimulus(0, 0, 0, 0, 0, 2'b01, 2, 0, 2'b11);
    for (int k = 0; k < 2; k++) chk("partial_strobe", o_rdata[k][31:0], 32'h11FF33FF);

    applyStimulus(0, 1, 5, 4'hF, 32'hDEADBEEF, 2'b10, 0, 5, 2'b11);
    chk("bypass_on", o_rdata[0][63:32], 32'hDEADBEEF);
    chk("bypass_off", o_rdata[1][63:32], 32'h0);

    applyStimulus(0, 1, 1, 4'hF, 32'h01010101, 2'b00, 0, 0, 2'b11);
    applyStimulus(0, 0, 0, 0, 0, 2'b11, 1, 2, 2'b10);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 2'b11, 1, (i == 0) ? 3'd3 : ((i == 1) ? 3'd5 : 3'd2), 2'b10);
      for (int k = 0; k < 2; k++) begin
        chk("held_rready0", 32'(o_rready[k][0]), 32'h0);
        chk("held_data0", o_rdata[k][31:0], 32'h01010101);
        chk("stream_p1", o_rdata[k][63:32], p1_exp[i]);
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 2'b11, 3, 0, 2'b11);
    for (int k = 0; k < 2; k++) begin
      chk("no_bubble_valid", 32'(o_rdvalid[k][0]), 32'h1);
      chk("no_bubble_data", o_rdata[k][31:0], 32'hA5A5A5A5);
    end

    applyStimulus(0, 1, 7, 4'hF, 32'hFFFFFFFF, 2'b00, 0, 0, 2'b11);
    applyStimulus(0, 1, 6, 4'hF, 32'h66666666, 2'b00, 0, 0, 2'b11);
    applyStimulus(0, 0, 0, 0, 0, 2'b11, 6, 7, 2'b11);
    chk("n8_addr6", o_rdata[0][31:0], 32'h66666666);
    chk("n8_addr7", o_rdata[0][63:32], 32'hFFFFFFFF);
    chk("n6_addr6", o_rdata[1][31:0], 32'h0);
    chk("n6_addr7", o_rdata[1][63:32], 32'h0);

    for (int a = 0; a < 8; a++)
      applyStimulus(0, 1, 3'(a), 4'hF, $urandom | 32'h1, 2'b00, 0, 0, 2'b11);
    applyStimulus(0, 0, 0, 0, 0, 2'b01, 4, 0, 2'b00);
    applyStimulus(1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00);
    for (int k = 0; k < 2; k++) begin
      busy_cnt[k] = int'(o_busy[k]);
      done_cnt[k] = int'(o_done[k]);
    end
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, (i < 5), 0, 4'hF, 32'hBAD0BAD0, 2'b11, 0, 0, 2'b00);
      for (int k = 0; k < 2; k++) begin
        if (i < 5) begin
          chk("sweep_wready", 32'(o_wready[k]), 32'h0);
          chk("sweep_rready", 32'(o_rready[k]), 32'h0);
        end
        busy_cnt[k] += int'(o_busy[k]);
        done_cnt[k] += int'(o_done[k]);
      end
    end
    chk("busy_cycles_n8", 32'(busy_cnt[0]), 32'd8);
    chk("busy_cycles_n6", 32'(busy_cnt[1]), 32'd6);
    chk("done_pulses_n8", 32'(done_cnt[0]), 32'd1);
    chk("done_pulses_n6", 32'(done_cnt[1]), 32'd1);
    for (int a = 0; a < 8; a++) begin
      applyStimulus(0, 0, 0, 0, 0, 2'b11, 3'(a), 3'(a), 2'b11);
      for (int k = 0; k < 2; k++) chk("after_clear", o_rdata[k][31:0], 32'h0);
    end

    randomCycles(1500);

    applyStimulus(0, 0, 0, 0, 0, 2'b11, 2, 3, 2'b00);
    applyStimulus(1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00);
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00);
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00);
    #2 arst_n = 1'b0;
    modelReset();
    #1 checkOutput();
    for (int k = 0; k < 2; k++) begin
      chk("midsweep_busy", 32'(o_busy[k]), 32'h0);
      chk("midsweep_rdvalid", 32'(o_rdvalid[k]), 32'h0);
      chk("midsweep_rdata", o_rdata[k][31:0], 32'h0);
    end
    @(negedge clk);
    arst_n = 1'b1;
    randomCycles(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
